// File: rtl/seven_segment_scan_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_pkg                                                          |
// | Shared state encoding and display constants for the scan controller. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic       ANODE_OFF = 1'b1;

endpackage
`default_nettype wire

// File: rtl/seven_segment_scan_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_segment_scan_controller_if                                     |
// | Frame load, shared-decoder and display-pin signals of the controller.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface seven_segment_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [6:0]              segment_in;
    logic [3:0]              bcd_out;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done;
    logic                    invalid_seen;

    modport master (
        output enable, load, digits_in, segment_in,
        input  bcd_out, seg_out, an_out, frame_done, invalid_seen
    );

    modport slave (
        input  enable, load, digits_in, segment_in,
        output bcd_out, seg_out, an_out, frame_done, invalid_seen
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scan_controller_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | scan_prescaler                                                       |
// | Per-slot cycle counter with slot-wrap pulse and guard-band end flag. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module scan_prescaler #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic run,
    output logic      wrap,
    output logic      guard_end
);
    localparam int c_CNT_W = $clog2(SCAN_DIV);

    logic [c_CNT_W-1:0] r_cnt;

    // Held at zero while not running so every scan starts on a fresh slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!run || wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign wrap      = (r_cnt == c_CNT_W'(SCAN_DIV - 1));
    assign guard_end = (r_cnt == c_CNT_W'(BLANK_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/seven_segment_scan_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_segment_scan_controller                                        |
// | Multiplexed common-anode scan with double-buffered BCD frame and     |
// | guard-band blanking. LEADING_ZERO_BLANK_EN enables leading-zero      |
// | suppression.                                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module seven_segment_scan_controller
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    seven_segment_scan_controller_if.slave   bus
);
    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_BUF_W = 4 * NUM_DIGITS;

    scan_state_t        r_state, w_state_next;
    logic [c_IDX_W-1:0] r_idx, w_idx_next;
    logic [c_BUF_W-1:0] r_pend, r_disp, w_pend_next, w_disp_next;
    logic [3:0]         r_bcd;
    logic [6:0]         r_seg;
    logic               r_inv;
    logic               w_wrap, w_guard_end, w_frame_end, w_enter_blank;
    logic               w_last_idx, w_lz_blank, w_show_en;
    logic [NUM_DIGITS-1:0] w_an;

    scan_prescaler #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .run       (bus.enable && (r_state != IDLE)),
        .wrap      (w_wrap),
        .guard_end (w_guard_end)
    );

    assign w_last_idx  = (r_idx == c_IDX_W'(NUM_DIGITS - 1));
    assign w_frame_end = (r_state == SHOW) && bus.enable && w_wrap && w_last_idx;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            IDLE:    if (bus.enable) w_state_next = BLANK;
            BLANK:   if (!bus.enable) w_state_next = IDLE;
                     else if (w_guard_end) w_state_next = SHOW;
            SHOW:    if (!bus.enable) w_state_next = IDLE;
                     else if (w_wrap) w_state_next = BLANK;
            default: w_state_next = IDLE;
        endcase
        if (r_state == IDLE || w_state_next == IDLE) begin
            w_idx_next = '0;
        end else if (r_state == SHOW && w_wrap) begin
            w_idx_next = w_last_idx ? '0 : r_idx + c_IDX_W'(1);
        end
    end

    assign w_enter_blank = (w_state_next == BLANK) && (r_state != BLANK);

    // A load landing on the frame boundary bypasses pending so it is not lost.
    assign w_pend_next = bus.load ? bus.digits_in : r_pend;
    assign w_disp_next = (r_state == IDLE || w_frame_end) ? w_pend_next : r_disp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_pend  <= '0;
            r_disp  <= '0;
            r_bcd   <= '0;
            r_seg   <= '0;
            r_inv   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_pend  <= w_pend_next;
            r_disp  <= w_disp_next;
            if (w_enter_blank) begin
                r_bcd <= 4'(w_disp_next >> {w_idx_next, 2'b00});
            end
            if (r_state == BLANK) begin
                r_seg <= bus.segment_in;
            end
            if (bus.load) begin
                r_inv <= 1'b0;
            end else if (r_state == SHOW && r_bcd > BCD_MAX) begin
                r_inv <= 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every more-significant digit are zero.
    assign w_lz_blank = (r_idx != '0) && ((r_disp >> {r_idx, 2'b00}) == '0);
`else
    assign w_lz_blank = 1'b0;
`endif

    // r_bcd always holds the current slot's display digit during SHOW.
    assign w_show_en = (r_state == SHOW) && (r_bcd <= BCD_MAX) && !w_lz_blank;

    always_comb begin
        w_an = {NUM_DIGITS{ANODE_OFF}};
        if (w_show_en) begin
            w_an[r_idx] = ~ANODE_OFF;
        end
    end

    assign bus.bcd_out      = r_bcd;
    assign bus.seg_out      = r_seg;
    assign bus.an_out       = w_an;
    assign bus.frame_done   = w_frame_end;
    assign bus.invalid_seen = r_inv;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_controller.sv
`default_nettype none
// Testbench for seven_segment_scan_controller: vector table, corner-case
// sequences and a randomized run against a slot/frame-arithmetic model.
module tb_seven_segment_scan_controller;
    localparam int N = 4;
    localparam int S = 8;
    localparam int B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seven_segment_scan_controller_if #(.NUM_DIGITS(N)) bus();

    seven_segment_scan_controller #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (S),
        .BLANK_CYCLES (B)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Shared decoder, active-low gfedcba; non-BCD codes light nothing.
    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign bus.segment_in = dec(bus.bcd_out);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] digit_of(input logic [15:0] v, input int s);
        return v[4*s +: 4];
    endfunction

    function automatic bit lz(input logic [15:0] v, input int s);
        bit lz_en;
`ifdef LEADING_ZERO_BLANK_EN
        lz_en = 1'b1;
`else
        lz_en = 1'b0;
`endif
        return lz_en && (s != 0) && ((v >> (4*s)) == 16'h0);
    endfunction

    // Reference model: time since scan start, pending and displayed frames.
    bit          m_active;
    int          m_k;
    logic [15:0] m_pend, m_disp;
    bit          m_inv;

    task automatic model_reset();
        m_active = 0; m_k = 0; m_pend = '0; m_disp = '0; m_inv = 0;
    endtask

    task automatic cyc(input bit en, input bit ld, input logic [15:0] din);
        int slot, pos;
        logic [3:0] d, exp_an;
        bit exp_fd;
        logic [15:0] new_pend;
        bus.enable = en; bus.load = ld; bus.digits_in = din;
        @(negedge clk);
        exp_an = 4'hF; exp_fd = 0; slot = 0; pos = 0; d = '0;
        if (m_active) begin
            slot = (m_k / S) % N;
            pos  = m_k % S;
            d    = digit_of(m_disp, slot);
            if (pos >= B && d <= 4'd9 && !lz(m_disp, slot)) exp_an[slot] = 1'b0;
            exp_fd = en && (slot == N-1) && (pos == S-1);
            check("bcd_out", bus.bcd_out, d);
            if (pos >= 1) check("seg_out", bus.seg_out, dec(d));
        end
        check("an_out", bus.an_out, exp_an);
        check("frame_done", bus.frame_done, exp_fd);
        check("invalid_seen", bus.invalid_seen, m_inv);
        new_pend = ld ? din : m_pend;
        if (ld) m_inv = 0;
        else if (m_active && pos >= B && d > 4'd9) m_inv = 1;
        if (!m_active) begin
            m_disp = new_pend;
            if (en) begin m_active = 1; m_k = 0; end
        end else if (!en) begin
            m_active = 0; m_k = 0;
        end else begin
            if (m_k % (N*S) == N*S-1) m_disp = new_pend;
            m_k++;
        end
        m_pend = new_pend;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [15:0] digits;
        logic [15:0] an;     // expected an_out of slot s at [4s+:4]
        logic        inv;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit en_r, ld;
        logic [15:0] v;

        tbl[0] = '{16'h1234, 16'h7BDE, 1'b0};
        tbl[1] = '{16'h9876, 16'h7BDE, 1'b0};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[2] = '{16'h0A00, 16'hFFDE, 1'b1};
        tbl[3] = '{16'h0045, 16'hFFDE, 1'b0};
        tbl[4] = '{16'h0000, 16'hFFFE, 1'b0};
`else
        tbl[2] = '{16'h0A00, 16'h7FDE, 1'b1};
        tbl[3] = '{16'h0045, 16'h7BDE, 1'b0};
        tbl[4] = '{16'h0000, 16'h7BDE, 1'b0};
`endif

        bus.enable = 0; bus.load = 0; bus.digits_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_an", bus.an_out, 4'hF);
        check("reset_seg", bus.seg_out, 7'h00);
        check("reset_bcd", bus.bcd_out, 4'h0);
        check("reset_fd", bus.frame_done, 1'b0);
        check("reset_inv", bus.invalid_seen, 1'b0);
        rst = 0;

        // Vector table: one frame per entry, sampled mid-SHOW of every slot.
        for (int r = 0; r < 5; r++) begin
            cyc(0, 0, '0);
            cyc(0, 1, tbl[r].digits);
            cyc(1, 0, '0);
            for (int i = 0; i < N*S; i++) begin
                if (i % S == 0) check("tbl_blank_an", bus.an_out, 4'hF);
                if (i % S == 4) begin
                    check("tbl_an", bus.an_out, tbl[r].an[4*(i/S) +: 4]);
                    check("tbl_bcd", bus.bcd_out, digit_of(tbl[r].digits, i/S));
                end
                if (i == N*S-1) check("tbl_fd", bus.frame_done, 1'b1);
                cyc(1, 0, '0);
            end
            check("tbl_inv", bus.invalid_seen, tbl[r].inv);
        end

        // Mid-frame load, then a load coincident with frame_done.
        cyc(0, 0, '0);
        cyc(0, 1, 16'h1234);
        cyc(1, 0, '0);
        for (int i = 0; i < 3*N*S; i++) begin
            ld = 0; v = '0;
            if (i == 10) begin ld = 1; v = 16'h5678; end
            if (i == 2*N*S-1) begin
                check("seq_fd_boundary", bus.frame_done, 1'b1);
                ld = 1; v = 16'h4321;
            end
            if (i % S == 4)
                check("seq_bcd", bus.bcd_out,
                      digit_of((i < N*S) ? 16'h1234 : (i < 2*N*S) ? 16'h5678 : 16'h4321, (i/S) % N));
            cyc(1, ld, v);
        end

        // Enable dropped during SHOW of digit 2, then re-enabled.
        for (int i = 0; i < 2*S+4; i++) cyc(1, 0, '0);
        check("drop_show_an", bus.an_out, 4'b1011);
        cyc(0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            check("drop_idle_an", bus.an_out, 4'hF);
            check("drop_no_fd", bus.frame_done, 1'b0);
            cyc(0, 0, '0);
        end
        cyc(1, 0, '0);
        check("reen_blank_an", bus.an_out, 4'hF);
        check("reen_bcd", bus.bcd_out, 4'h1);
        cyc(1, 0, '0);
        cyc(1, 0, '0);
        check("reen_show_an", bus.an_out, 4'hE);

        // Asynchronous reset in the middle of a SHOW slot.
        cyc(1, 0, '0);
        #2 rst = 1;
        #1;
        check("areset_an", bus.an_out, 4'hF);
        check("areset_seg", bus.seg_out, 7'h00);
        check("areset_bcd", bus.bcd_out, 4'h0);
        bus.enable = 0; bus.load = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();

        // Randomized run against the model.
        en_r = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom % 150 == 0) en_r = !en_r;
            ld = ($urandom % 25 == 0);
            for (int j = 0; j < N; j++)
                v[4*j +: 4] = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
            if ($urandom % 3 == 0) v[15:8] = 8'h00;
            cyc(en_r, ld, v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
